shift_ram_reader: RTL and testbench

- Read-side companion to the line-buffer shift RAM.
- Drives the RAM's combinational read address and captures one full line of DATA_WIDTH*LENGTH bits.
- Serialises that line as LENGTH words on a valid/ready stream, oldest word (LSBs) first.
- Streams a run of consecutive rows per command, wrapping at DEPTH; feeds the downstream window/compute stage.

---
 rtl/shift_ram_reader.sv | 163 ++++++++++++++++
 tb/tb_shift_ram_reader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_ram_reader.sv
// rtl/shift_ram_reader.sv - line-buffer shift RAM read-side serialiser
//
// Fetches whole rows from the shift RAM through a registered read address and
// streams each row as LENGTH words of DATA_WIDTH bits, LSB word (oldest) first,
// on a valid/ready stream. One command streams num_rows consecutive rows
// starting at start_row, wrapping from DEPTH-1 to 0.
//
// Optional build macro: SHIFT_RAM_READER_PREFETCH_EN
//   undefined : one FETCH bubble between rows, rd_addr moves only at row boundaries
//   defined   : next row address is presented while the current row streams,
//               giving back-to-back rows with no bubble
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             command strobe, sampled only when idle
//   start_row         first row of the command (< DEPTH)
//   num_rows          rows to stream, 0 completes with no data
//   rd_addr           registered read address to the shift RAM
//   line_in           shift RAM read data for rd_addr (combinational)
//   dout              current word
//   dout_valid        word available
//   dout_ready        downstream accepts
//   dout_last         final word of the final row
//   busy              command in progress
//   done              one-cycle completion pulse

module shift_ram_reader #(
   parameter int DEPTH      = 16,
   parameter int DATA_WIDTH = 16,
   parameter int LENGTH     = 25
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [7:0]                   start_row,
   input  logic [7:0]                   num_rows,
   output logic [7:0]                   rd_addr,
   input  logic [DATA_WIDTH*LENGTH-1:0] line_in,
   output logic [DATA_WIDTH-1:0]        dout,
   output logic                         dout_valid,
   input  logic                         dout_ready,
   output logic                         dout_last,
   output logic                         busy,
   output logic                         done
);

   localparam int LINE_W = DATA_WIDTH * LENGTH;
   localparam int CNT_W  = $clog2(LENGTH + 1);
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LENGTH - 1);
   localparam logic [7:0]       LAST_ROW  = 8'(DEPTH - 1);
   localparam logic             ONE_WORD  = (LENGTH == 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FETCH  = 2'd1,
      S_STREAM = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t            state;
   logic [LINE_W-1:0] line_buf;
   logic [CNT_W-1:0]  word_cnt;
   logic [7:0]        rows_left;

   logic [7:0] next_addr;
   logic       xfer;
   logic       final_word;

   assign next_addr  = (rd_addr == LAST_ROW) ? 8'd0 : rd_addr + 8'd1;
   assign xfer       = dout_valid & dout_ready;
   assign final_word = (word_cnt == LAST_WORD);
   assign dout       = line_buf[DATA_WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         rd_addr    <= 8'd0;
         line_buf   <= '0;
         word_cnt   <= '0;
         rows_left  <= 8'd0;
         dout_valid <= 1'b0;
         dout_last  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (num_rows != 8'd0) begin
                     rd_addr   <= start_row;
                     rows_left <= num_rows;
                     state     <= S_FETCH;
                  end else begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end
               end
            end

            S_FETCH: begin
               line_buf   <= line_in;
               word_cnt   <= '0;
               dout_valid <= 1'b1;
               dout_last  <= (rows_left == 8'd1) && ONE_WORD;
               state      <= S_STREAM;
`ifdef SHIFT_RAM_READER_PREFETCH_EN
               // Present the following row now so it is ready at handoff.
               if (rows_left > 8'd1)
                  rd_addr <= next_addr;
`endif
            end

            S_STREAM: begin
               if (xfer) begin
                  if (final_word && rows_left == 8'd1) begin
                     line_buf   <= line_buf >> DATA_WIDTH;
                     word_cnt   <= word_cnt + CNT_W'(1);
                     dout_valid <= 1'b0;
                     dout_last  <= 1'b0;
                     done       <= 1'b1;
                     state      <= S_DONE;
                  end else if (final_word) begin
                     rows_left <= rows_left - 8'd1;
`ifdef SHIFT_RAM_READER_PREFETCH_EN
                     // rd_addr already points at the next row; load it directly.
                     line_buf  <= line_in;
                     word_cnt  <= '0;
                     dout_last <= (rows_left == 8'd2) && ONE_WORD;
                     if (rows_left > 8'd2)
                        rd_addr <= next_addr;
`else
                     line_buf   <= line_buf >> DATA_WIDTH;
                     word_cnt   <= word_cnt + CNT_W'(1);
                     rd_addr    <= next_addr;
                     dout_valid <= 1'b0;
                     dout_last  <= 1'b0;
                     state      <= S_FETCH;
`endif
                  end else begin
                     line_buf  <= line_buf >> DATA_WIDTH;
                     word_cnt  <= word_cnt + CNT_W'(1);
                     // Flag the word that becomes current after this shift.
                     dout_last <= (rows_left == 8'd1) &&
                                  ((word_cnt + CNT_W'(1)) == LAST_WORD);
                  end
               end
            end

            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_ram_reader.sv
// tb/tb_shift_ram_reader.sv - randomized scoreboard bench for shift_ram_reader

module tb_shift_ram_reader;

   localparam int D  = 16;
   localparam int DW = 16;
   localparam int L  = 4;

`ifdef SHIFT_RAM_READER_PREFETCH_EN
   localparam int GAP = 0;
`else
   localparam int GAP = 1;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [7:0]      start_row;
   logic [7:0]      num_rows;
   logic [7:0]      rd_addr;
   logic [DW*L-1:0] line_in;
   logic [DW-1:0]   dout;
   logic            dout_valid;
   logic            dout_ready;
   logic            dout_last;
   logic            busy;
   logic            done;

   logic [DW*L-1:0] mem [D];

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } exp_t;

   exp_t sb[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int start_neg = 0;
   int first_valid_cyc = -1;
   int done_cyc = -1;
   int done_cnt = 0;
   int xfer_cnt = 0;
   int rmode = 0;
   int pidx = 0;
   bit watch7 = 1'b0;

   always #5 clk = ~clk;

   assign line_in = mem[rd_addr[3:0]];

   shift_ram_reader #(.DEPTH(D), .DATA_WIDTH(DW), .LENGTH(L)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .start_row  (start_row),
      .num_rows   (num_rows),
      .rd_addr    (rd_addr),
      .line_in    (line_in),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout_last  (dout_last),
      .busy       (busy),
      .done       (done)
   );

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: row r of the command is (start_row + r) mod DEPTH, words LSB first.
   task automatic push_cmd(input int sr, input int nr);
      exp_t e;
      logic [DW*L-1:0] row_data;
      for (int r = 0; r < nr; r++) begin
         row_data = mem[(sr + r) % D];
         for (int k = 0; k < L; k++) begin
            e.data = row_data[k*DW +: DW];
            e.last = (r == nr - 1) && (k == L - 1);
            sb.push_back(e);
         end
      end
   endtask

   task automatic fill_random();
      for (int r = 0; r < D; r++)
         mem[r] = {$urandom, $urandom};
   endtask

   task automatic issue(input int sr, input int nr);
      @(posedge clk); #1;
      start = 1'b1; start_row = 8'(sr); num_rows = 8'(nr);
      push_cmd(sr, nr);
      start_neg = cyc + 1;
      first_valid_cyc = -1;
      done_cyc = -1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      int n = 0;
      while (done_cyc < 0 && n < bound) begin
         @(negedge clk); #1;
         n++;
      end
      check("done_seen", done_cyc >= 0, 1);
      @(negedge clk); #1;
      check("busy_after_done", busy, 0);
      check("sb_empty", sb.size(), 0);
   endtask

   // Ready driver
   initial begin
      dout_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (rmode)
            0: dout_ready = 1'b1;
            1: begin
               dout_ready = (pidx % 3 == 0);
               pidx++;
            end
            default: dout_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Monitor
   initial begin
      exp_t e;
      bit hold_pending = 1'b0;
      logic [DW-1:0] held = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            hold_pending = 1'b0;
         end else begin
            if (hold_pending) begin
               check("hold_valid", dout_valid, 1);
               check("hold_data", dout, held);
            end
            hold_pending = dout_valid && !dout_ready;
            held = dout;
            if (dout_valid && first_valid_cyc < 0)
               first_valid_cyc = cyc;
            if (dout_valid && dout_ready) begin
               xfer_cnt++;
               if (sb.size() == 0) begin
                  check("unexpected_word", 1, 0);
               end else begin
                  e = sb.pop_front();
                  check("dout", dout, e.data);
                  check("dout_last", dout_last, e.last);
               end
            end
            if (done) begin
               done_cnt++;
               if (done_cyc < 0)
                  done_cyc = cyc;
            end
            if (watch7)
               check("rd_addr_not_7", rd_addr == 8'd7, 0);
         end
      end
   end

   initial begin
      int dc0;
      int x0;
      int n;
      rst = 1'b1; start = 1'b0; start_row = 8'd0; num_rows = 8'd0;
      fill_random();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk); #1;
      check("rst_valid", dout_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_last", dout_last, 0);
      check("rst_addr", rd_addr, 0);
      check("rst_dout", dout, 0);

      // Zero rows
      issue(5, 0);
      wait_done(10);
      check("zero_done_lat_ok", (done_cyc - start_neg >= 1) && (done_cyc - start_neg <= 2), 1);
      check("zero_no_valid", first_valid_cyc, -1);
      check("zero_addr", rd_addr, 0);

      // Single row, ready=1
      mem[3] = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
      issue(3, 1);
      wait_done(40);
      check("first_valid_lat", first_valid_cyc - start_neg, 2);
      check("single_done_lat", done_cyc - start_neg, 2 + L);

      // Back-pressure 1,0,0,...
      rmode = 1; pidx = 0;
      x0 = xfer_cnt;
      issue(3, 1);
      wait_done(60);
      check("bp_xfers", xfer_cnt - x0, L);
      rmode = 0;

      // Wrap 15 -> 0
      for (int k = 0; k < L; k++) begin
         mem[15][k*DW +: DW] = 16'h000F + 16'(k * 16);
         mem[0][k*DW +: DW]  = 16'h00A0 + 16'(k);
      end
      issue(15, 2);
      wait_done(60);
      check("wrap_done_lat", done_cyc - start_neg, 2 + 2 * L + GAP);

      // Start while busy
      fill_random();
      dc0 = done_cnt;
      watch7 = 1'b1;
      x0 = xfer_cnt;
      issue(1, 2);
      n = 0;
      while (xfer_cnt - x0 < 2 && n < 40) begin
         @(negedge clk); #1;
         n++;
      end
      check("busy_mid_reached", xfer_cnt - x0 >= 2, 1);
      @(posedge clk); #1;
      start = 1'b1; start_row = 8'd7; num_rows = 8'd3;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(60);
      repeat (5) @(negedge clk);
      #1;
      check("busy_single_done", done_cnt - dc0, 1);
      watch7 = 1'b0;

      // Reset mid-stream
      dc0 = done_cnt;
      x0 = xfer_cnt;
      issue(9, 2);
      n = 0;
      while (xfer_cnt - x0 < 2 && n < 40) begin
         @(negedge clk); #1;
         n++;
      end
      check("rst_mid_reached", xfer_cnt - x0, 2);
      @(posedge clk); #1;
      rst = 1'b1;
      start = 1'b1; start_row = 8'd4; num_rows = 8'd1;
      @(posedge clk); #1;
      rst = 1'b0;
      start = 1'b0;
      sb.delete();
      @(negedge clk); #1;
      check("mid_rst_valid", dout_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_addr", rd_addr, 0);
      repeat (4) @(negedge clk);
      #1;
      check("mid_rst_no_done", done_cnt - dc0, 0);
      check("mid_rst_idle", busy, 0);
      issue(6, 1);
      wait_done(40);
      check("post_rst_lat", done_cyc - start_neg, 2 + L);

      // Randomized commands
      for (int t = 0; t < 12; t++) begin
         fill_random();
         rmode = $urandom_range(0, 2);
         issue($urandom_range(0, D - 1), $urandom_range(1, 4));
         wait_done(400);
      end
      rmode = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
